// File: rtl/redmule_mesh_pkg.sv
// redmule_mesh_pkg: shared mesh constants and barrier FSM state type
package redmule_mesh_pkg;
  localparam int N_TILES = 4;
  localparam int DEFAULT_STABLE_CYCLES = 4;
  localparam int DEFAULT_PULSE_CYCLES = 2;
  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_SETTLE, ST_WAKE, ST_DRAIN} barrier_state_e;
endpackage

// File: rtl/redmule_mesh_barrier_cnt.sv
// redmule_mesh_barrier_cnt: up-counter with clear, enable and terminal-count flag
module redmule_mesh_barrier_cnt #(
  parameter int W = 4,
  parameter logic [W-1:0] LAST = '1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] q_o,
  output logic         tc_o
);
  always_ff @(posedge clk_i)
    q_o <= (!rst_ni || clr_i) ? '0 : en_i ? q_o + W'(1) : q_o;
  assign tc_o = q_o == LAST;
endmodule

// File: rtl/redmule_mesh_barrier.sv
// redmule_mesh_barrier: mesh WFE barrier that wakes all masked tiles once they have settled asleep
module redmule_mesh_barrier #(
  parameter int N_TILES = redmule_mesh_pkg::N_TILES,
  parameter int STABLE_CYCLES = redmule_mesh_pkg::DEFAULT_STABLE_CYCLES,
  parameter int PULSE_CYCLES = redmule_mesh_pkg::DEFAULT_PULSE_CYCLES,
  parameter int CNT_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               enable_i,
  input  logic [N_TILES-1:0] tile_mask_i,
  input  logic [N_TILES-1:0] core_sleep_i,
  output logic [N_TILES-1:0] wu_wfe_o,
  output logic               barrier_done_o,
  output logic [CNT_W-1:0]   barrier_cnt_o,
  output logic               busy_o
);
  import redmule_mesh_pkg::*;
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int PW = $clog2(PULSE_CYCLES + 1);
  barrier_state_e state, next;
  logic [N_TILES-1:0] mask_q;
  logic [SW-1:0] sc;
  logic [PW-1:0] pc;
  logic all_asleep, any_asleep, sc_en, sc_tc, pc_tc, retire, cnt_tc, unused_ok;
  assign all_asleep = &(core_sleep_i | ~mask_q);
  assign any_asleep = |(core_sleep_i & mask_q);
  assign retire = state == ST_DRAIN && !any_asleep;
  // settle count runs only while every masked tile is asleep; any other cycle restarts it
  assign sc_en = (state == ST_WAIT || state == ST_SETTLE) && enable_i && all_asleep;
  assign unused_ok = ^{sc, pc, cnt_tc};
  always_ff @(posedge clk_i)
    state <= rst_ni ? next : ST_IDLE;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mask_q <= '0;
      barrier_done_o <= 1'b0;
    end else begin
      if (state == ST_IDLE && enable_i && |tile_mask_i) mask_q <= tile_mask_i;
      barrier_done_o <= retire;
    end
  end
  always_comb begin
    next = state;
    case (state)
      ST_IDLE:   next = (enable_i && |tile_mask_i) ? ST_WAIT : ST_IDLE;
      ST_WAIT:   next = !enable_i ? ST_IDLE : !all_asleep ? ST_WAIT : (STABLE_CYCLES == 1) ? ST_WAKE : ST_SETTLE;
      ST_SETTLE: next = !enable_i ? ST_IDLE : !all_asleep ? ST_WAIT : sc_tc ? ST_WAKE : ST_SETTLE;
      ST_WAKE:   next = pc_tc ? ST_DRAIN : ST_WAKE;
      ST_DRAIN:  next = any_asleep ? ST_DRAIN : enable_i ? ST_WAIT : ST_IDLE;
      default:   next = ST_IDLE;
    endcase
  end
  always_comb begin
    wu_wfe_o = (state == ST_WAKE) ? mask_q : '0;
    busy_o = state != ST_IDLE;
  end
  redmule_mesh_barrier_cnt #(.W(SW), .LAST(SW'(STABLE_CYCLES - 1))) u_settle (
    .clk_i, .rst_ni, .clr_i(!sc_en), .en_i(sc_en), .q_o(sc), .tc_o(sc_tc)
  );
  redmule_mesh_barrier_cnt #(.W(PW), .LAST(PW'(PULSE_CYCLES - 1))) u_pulse (
    .clk_i, .rst_ni, .clr_i(state != ST_WAKE), .en_i(state == ST_WAKE), .q_o(pc), .tc_o(pc_tc)
  );
  redmule_mesh_barrier_cnt #(.W(CNT_W)) u_barrier (
    .clk_i, .rst_ni, .clr_i(1'b0), .en_i(retire), .q_o(barrier_cnt_o), .tc_o(cnt_tc)
  );
endmodule

// File: tb/tb_redmule_mesh_barrier.sv
// tb_redmule_mesh_barrier: vector table, directed corner cases and random run against a behavioural model
module tb_redmule_mesh_barrier;
  localparam int S = 4, P = 2;
  logic clk = 0, rst_n = 0, en = 0;
  logic [3:0] mask = 0, sleep = 0, wu, wu1;
  logic done, busy, done1_unused, busy1_unused;
  logic [1:0] cnt;
  logic [15:0] cnt1_unused;
  int vectors = 0, miscompares = 0;
  logic [3:0] m_mask = 0;
  logic [1:0] m_cnt = 0;
  bit m_active = 0, m_drain = 0, m_done = 0;
  int m_run = 0, m_wake = 0;
  typedef struct {
    logic rst_n, en;
    logic [3:0] mask, sleep, wu;
    logic done, busy;
    logic [1:0] cnt;
  } vec_t;
  vec_t tbl[12];
  logic [1:0] wrap_exp[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  always #5 clk = ~clk;
  redmule_mesh_barrier #(.N_TILES(4), .STABLE_CYCLES(S), .PULSE_CYCLES(P), .CNT_W(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .tile_mask_i(mask), .core_sleep_i(sleep),
    .wu_wfe_o(wu), .barrier_done_o(done), .barrier_cnt_o(cnt), .busy_o(busy)
  );
  redmule_mesh_barrier #(.N_TILES(4), .STABLE_CYCLES(1), .PULSE_CYCLES(P), .CNT_W(16)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .tile_mask_i(mask), .core_sleep_i(sleep),
    .wu_wfe_o(wu1), .barrier_done_o(done1_unused), .barrier_cnt_o(cnt1_unused), .busy_o(busy1_unused)
  );
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // model: counts consecutive all-asleep cycles, then a fixed pulse, then waits for the masked tiles to wake
  task automatic model_step();
    if (!rst_n) begin
      m_mask = 0; m_active = 0; m_drain = 0; m_done = 0; m_run = 0; m_wake = 0; m_cnt = 0;
    end else begin
      m_done = 0;
      if (m_wake > 0) begin
        m_wake--;
        if (m_wake == 0) m_drain = 1;
      end else if (m_drain) begin
        if ((sleep & m_mask) == 4'h0) begin
          m_cnt++; m_done = 1; m_drain = 0; m_active = en; m_run = 0;
        end
      end else if (m_active) begin
        if (!en) begin
          m_active = 0; m_run = 0;
        end else if ((sleep | ~m_mask) == 4'hF) begin
          m_run++;
          if (m_run == S) begin m_active = 0; m_wake = P; m_run = 0; end
        end else m_run = 0;
      end else if (en && mask != 4'h0) begin
        m_mask = mask; m_active = 1; m_run = 0;
      end
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check("model", {wu, done, busy, cnt},
          {(m_wake > 0 ? m_mask : 4'h0), m_done, (m_active || m_wake > 0 || m_drain), m_cnt});
  endtask
  task automatic release_and_idle();
    sleep = 0;
    for (int k = 0; k < 4; k++) cyc();
    en = 0;
    cyc();
  endtask
  task automatic barrier(output logic [1:0] c, output bit ok);
    en = 1; mask = 4'hF; sleep = 4'hF; ok = 0; c = 'x;
    for (int k = 0; k < 30; k++) begin
      cyc();
      if (wu != 0) sleep = 0;
      if (done) begin ok = 1; c = cnt; break; end
    end
  endtask
  initial begin
    int first;
    logic [3:0] acc;
    logic [1:0] c0;
    bit seen, ok;
    tbl[0]  = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0};
    tbl[1]  = '{1'b1, 1'b1, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 2'd0};
    tbl[2]  = '{1'b1, 1'b1, 4'hF, 4'hF, 4'h0, 1'b0, 1'b1, 2'd0};
    tbl[3]  = '{1'b1, 1'b1, 4'hF, 4'hF, 4'h0, 1'b0, 1'b1, 2'd0};
    tbl[4]  = '{1'b1, 1'b1, 4'hF, 4'hF, 4'h0, 1'b0, 1'b1, 2'd0};
    tbl[5]  = '{1'b1, 1'b1, 4'hF, 4'hF, 4'hF, 1'b0, 1'b1, 2'd0};
    tbl[6]  = '{1'b1, 1'b1, 4'hF, 4'hF, 4'hF, 1'b0, 1'b1, 2'd0};
    tbl[7]  = '{1'b1, 1'b1, 4'hF, 4'hF, 4'h0, 1'b0, 1'b1, 2'd0};
    tbl[8]  = '{1'b1, 1'b1, 4'hF, 4'hF, 4'h0, 1'b0, 1'b1, 2'd0};
    tbl[9]  = '{1'b1, 1'b1, 4'hF, 4'h0, 4'h0, 1'b1, 1'b1, 2'd1};
    tbl[10] = '{1'b1, 1'b1, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 2'd1};
    tbl[11] = '{1'b1, 1'b0, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 2'd1};
    foreach (tbl[i]) begin
      rst_n = tbl[i].rst_n; en = tbl[i].en; mask = tbl[i].mask; sleep = tbl[i].sleep;
      cyc();
      check($sformatf("basic_row%0d", i), {wu, done, busy, cnt},
            {tbl[i].wu, tbl[i].done, tbl[i].busy, tbl[i].cnt});
    end
    // tile 2 blinks awake in the third settle cycle
    en = 1; mask = 4'hF; sleep = 0;
    cyc();
    first = -1;
    for (int k = 0; k < 12; k++) begin
      sleep = (k == 2) ? 4'hB : 4'hF;
      cyc();
      if (first < 0 && wu != 0) first = k + 1;
    end
    check("glitch_wake_cycle", first, 7);
    release_and_idle();
    mask = 4'h5; en = 1; sleep = 4'h5; acc = 0; seen = 0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      acc |= wu & 4'hA;
      if (wu != 0) sleep = 0;
      if (done) seen = 1;
    end
    check("partial_unmasked_wu", acc, 0);
    check("partial_done", seen, 1);
    en = 0;
    cyc();
    mask = 4'hF; en = 1; sleep = 0;
    cyc();
    sleep = 4'hF;
    cyc();
    cyc();
    en = 0;
    cyc();
    check("dis_settle_busy", busy, 0);
    acc = 0;
    for (int k = 0; k < 6; k++) begin cyc(); acc |= wu; end
    check("dis_settle_nowake", acc, 0);
    en = 1;
    for (int k = 0; k < 12 && wu == 0; k++) cyc();
    check("dis_wake_reached", wu, 4'hF);
    c0 = cnt; en = 0; seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (k == 3) sleep = 0;
      cyc();
      if (done) seen = 1;
    end
    check("dis_wake_done", seen, 1);
    check("dis_wake_cnt", cnt, 2'(c0 + 2'd1));
    check("dis_wake_idle", busy, 0);
    rst_n = 0;
    cyc();
    rst_n = 1;
    for (int b = 0; b < 5; b++) begin
      barrier(c0, ok);
      check($sformatf("wrap_barrier%0d", b), {ok, c0}, {1'b1, wrap_exp[b]});
    end
    release_and_idle();
    en = 1; sleep = 4'hF;
    for (int k = 0; k < 12 && wu == 0; k++) cyc();
    rst_n = 0;
    cyc();
    check("reset_mid_wake", {wu, done, busy, cnt}, 0);
    rst_n = 1; mask = 4'hF; en = 1; sleep = 0;
    cyc();
    check("s1_before_sleep", wu1, 0);
    sleep = 4'hF;
    cyc();
    check("s1_wake_latency", wu1, 4'hF);
    release_and_idle();
    for (int i = 0; i < 1500; i++) begin
      int r;
      rst_n = $urandom_range(0, 149) != 0;
      en = $urandom_range(0, 9) != 0;
      if ($urandom_range(0, 19) == 0) mask = 4'($urandom);
      r = $urandom_range(0, 9);
      sleep = r < 5 ? 4'hF : r < 8 ? 4'h0 : 4'($urandom);
      cyc();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
